// File: rtl/opsel_accum.sv
// Multi-channel operand-select / saturating-accumulate datapath.
// Beats pass S1 (operand select) then S2 (accumulator read-modify-write + output register).
module opsel_accum #(
  parameter int WIDTH     = 8,
  parameter int NCH       = 4,
  parameter int ACC_WIDTH = 2*WIDTH,
  parameter int CONST_VAL = 5,
  parameter int CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [1:0]           in_op,
  input  logic [CHW-1:0]       in_ch,
  input  logic                 in_clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic [CHW-1:0]       out_ch,
  output logic                 out_ovf
);

  localparam logic [CHW:0] NCH_W = (CHW+1)'(NCH);

  logic                 s1_valid_q, s1_valid_d;
  logic [ACC_WIDTH-1:0] s1_opnd_q, s1_opnd_d;
  logic [CHW-1:0]       s1_ch_q, s1_ch_d;
  logic                 s1_clr_q, s1_clr_d;

  logic                 out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
  logic [CHW-1:0]       out_ch_q, out_ch_d;
  logic                 out_ovf_q, out_ovf_d;

  logic [ACC_WIDTH-1:0] acc_q [NCH];
  logic [ACC_WIDTH-1:0] acc_d [NCH];
  logic                 ovf_q [NCH];
  logic                 ovf_d [NCH];

  logic                 adv2;
  logic                 accept;
  logic                 ch_ok;
  logic [WIDTH-1:0]     inv_data;
  logic [ACC_WIDTH-1:0] operand;
  logic [ACC_WIDTH-1:0] acc_cur, acc_new;
  logic                 ovf_cur, ovf_new;
  logic [ACC_WIDTH:0]   sum;

  assign adv2     = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready = !s1_valid_q || adv2;
  assign accept   = in_valid && in_ready;
  assign ch_ok    = {1'b0, in_ch} < NCH_W;
  assign inv_data = ~in_data;

  always_comb begin
    operand = '0;
    case (in_op)
      2'b00:   operand = ACC_WIDTH'(in_data) + ACC_WIDTH'(1);
      2'b01:   operand = ACC_WIDTH'(inv_data);
      2'b10:   operand = ACC_WIDTH'(CONST_VAL);
      default: operand = ACC_WIDTH'(in_data);
    endcase
  end

  // Out-of-range channels are swallowed here and never reach S2.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_opnd_d  = s1_opnd_q;
    s1_ch_d    = s1_ch_q;
    s1_clr_d   = s1_clr_q;
    if (in_ready) begin
      s1_valid_d = accept && ch_ok;
    end
    if (accept) begin
      s1_opnd_d = operand;
      s1_ch_d   = in_ch;
      s1_clr_d  = in_clr;
    end
  end

  always_comb begin
    acc_cur = '0;
    ovf_cur = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (s1_ch_q == CHW'(i)) begin
        acc_cur = acc_q[i];
        ovf_cur = ovf_q[i];
      end
    end
    sum = {1'b0, acc_cur} + {1'b0, s1_opnd_q};
    if (s1_clr_q) begin
      acc_new = s1_opnd_q;
      ovf_new = 1'b0;
    end else if (sum[ACC_WIDTH]) begin
      acc_new = '1;
      ovf_new = 1'b1;
    end else begin
      acc_new = sum[ACC_WIDTH-1:0];
      ovf_new = ovf_cur;
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      acc_d[i] = acc_q[i];
      ovf_d[i] = ovf_q[i];
      if (adv2 && s1_ch_q == CHW'(i)) begin
        acc_d[i] = acc_new;
        ovf_d[i] = ovf_new;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_ovf_d   = out_ovf_q;
    if (adv2) begin
      out_valid_d = 1'b1;
      out_data_d  = acc_new;
      out_ch_d    = s1_ch_q;
      out_ovf_d   = ovf_new;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q  <= 1'b0;
      s1_opnd_q   <= '0;
      s1_ch_q     <= '0;
      s1_clr_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_ovf_q   <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        acc_q[i] <= '0;
        ovf_q[i] <= 1'b0;
      end
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_opnd_q   <= s1_opnd_d;
      s1_ch_q     <= s1_ch_d;
      s1_clr_q    <= s1_clr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_ovf_q   <= out_ovf_d;
      for (int i = 0; i < NCH; i++) begin
        acc_q[i] <= acc_d[i];
        ovf_q[i] <= ovf_d[i];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_opsel_accum.sv
// Scoreboard bench for opsel_accum (NCH=3 so channel 3 is out of range).
module tb_opsel_accum;

  localparam int WIDTH     = 8;
  localparam int NCH       = 3;
  localparam int ACC_WIDTH = 16;
  localparam int CONST_VAL = 5;
  localparam int CHW       = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data = '0;
  logic [1:0]           in_op = '0;
  logic [CHW-1:0]       in_ch = '0;
  logic                 in_clr = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [ACC_WIDTH-1:0] out_data;
  logic [CHW-1:0]       out_ch;
  logic                 out_ovf;

  opsel_accum #(
    .WIDTH(WIDTH), .NCH(NCH), .ACC_WIDTH(ACC_WIDTH), .CONST_VAL(CONST_VAL), .CHW(CHW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_op(in_op),
    .in_ch(in_ch), .in_clr(in_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ACC_WIDTH-1:0] data;
    logic [CHW-1:0]       ch;
    logic                 ovf;
  } exp_t;

  exp_t                 exp_q[$];
  logic [ACC_WIDTH-1:0] m_acc [NCH];
  logic                 m_ovf [NCH];
  int                   tests_run = 0;
  int                   tests_failed = 0;
  int                   out_count = 0;
  logic [ACC_WIDTH-1:0] last_data = '0;
  logic                 last_ovf = 1'b0;

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_acc[i] = '0;
      m_ovf[i] = 1'b0;
    end
  endfunction

  // Reference behaviour applied in acceptance order.
  function automatic void model_beat(input logic [7:0] d, input logic [1:0] op,
                                     input logic [1:0] ch, input logic clr);
    logic [16:0] opnd;
    logic [16:0] sum;
    exp_t e;
    if (int'(ch) >= NCH) return;
    case (op)
      2'b00:   opnd = {9'b0, d} + 17'd1;
      2'b01:   opnd = {9'b0, ~d};
      2'b10:   opnd = 17'(CONST_VAL);
      default: opnd = {9'b0, d};
    endcase
    if (clr) begin
      m_acc[ch] = opnd[15:0];
      m_ovf[ch] = 1'b0;
    end else begin
      sum = {1'b0, m_acc[ch]} + opnd;
      if (sum[16]) begin
        m_acc[ch] = 16'hFFFF;
        m_ovf[ch] = 1'b1;
      end else begin
        m_acc[ch] = sum[15:0];
      end
    end
    e.data = m_acc[ch];
    e.ch   = ch;
    e.ovf  = m_ovf[ch];
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst && out_valid && out_ready) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL out_beat: unexpected output data=%h ch=%0d ovf=%b, required none",
                 out_data, out_ch, out_ovf);
      end else begin
        e = exp_q.pop_front();
        if ({out_data, out_ch, out_ovf} !== e) begin
          tests_failed++;
          $display("FAIL out_beat: got data=%h ch=%0d ovf=%b, required data=%h ch=%0d ovf=%b",
                   out_data, out_ch, out_ovf, e.data, e.ch, e.ovf);
        end
      end
      $display("[TB] out beat data=%h ch=%0d ovf=%b", out_data, out_ch, out_ovf);
      out_count++;
      last_data = out_data;
      last_ovf  = out_ovf;
    end
  end

  task automatic drive(input logic [7:0] d, input logic [1:0] op, input logic [1:0] ch,
                       input logic clr);
    in_valid = 1'b1;
    in_data  = d;
    in_op    = op;
    in_ch    = ch;
    in_clr   = clr;
  endtask

  task automatic wait_accept();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      tests_run++;
      tests_failed++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end else begin
      model_beat(in_data, in_op, in_ch, in_clr);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic [1:0] op, input logic [1:0] ch,
                      input logic clr);
    drive(d, op, ch, clr);
    wait_accept();
  endtask

  task automatic wait_drain();
    int n = 0;
    @(negedge clk);
    while (exp_q.size() != 0 && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain_timeout: %0d results pending, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    tests_run++;
    if (out_data !== 16'h0000) begin tests_failed++; $display("FAIL reset_out_data: got %h required 0000", out_data); end
    tests_run++;
    if (out_ch !== 2'd0 || out_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ch_ovf: got ch=%0d ovf=%b required 0/0", out_ch, out_ovf);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_latency();
    out_ready = 1'b1;
    send(8'hFF, 2'b00, 2'd0, 1'b1);
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL latency_early: out_valid=%b required 0", out_valid); end
    @(posedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 16'h0100 || out_ch !== 2'd0 || out_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL latency_out: got v=%b data=%h ch=%0d ovf=%b required 1/0100/0/0",
               out_valid, out_data, out_ch, out_ovf);
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int base = out_count;
    send(8'h03, 2'b11, 2'd1, 1'b1);
    send(8'h00, 2'b10, 2'd1, 1'b0);
    send(8'h0F, 2'b01, 2'd1, 1'b0);
    @(posedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 16'h00F8) begin
      tests_failed++;
      $display("FAIL b2b_third: got v=%b data=%h required 1/00f8", out_valid, out_data);
    end
    wait_drain();
    tests_run++;
    if (out_count - base != 3) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d outputs required 3", out_count - base);
    end
  endtask

  task automatic test_saturation();
    send(8'hFF, 2'b11, 2'd2, 1'b1);
    for (int i = 0; i < 256; i++) send(8'h00, 2'b01, 2'd2, 1'b0);
    wait_drain();
    tests_run++;
    if (last_data !== 16'hFFFF || last_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL sat_exact_fill: got %h ovf=%b required ffff/0", last_data, last_ovf);
    end
    send(8'h00, 2'b01, 2'd2, 1'b0);
    wait_drain();
    tests_run++;
    if (last_data !== 16'hFFFF || last_ovf !== 1'b1) begin
      tests_failed++;
      $display("FAIL sat_carry: got %h ovf=%b required ffff/1", last_data, last_ovf);
    end
    send(8'h00, 2'b11, 2'd2, 1'b0);
    wait_drain();
    tests_run++;
    if (last_data !== 16'hFFFF || last_ovf !== 1'b1) begin
      tests_failed++;
      $display("FAIL sat_sticky: got %h ovf=%b required ffff/1", last_data, last_ovf);
    end
    send(8'h01, 2'b11, 2'd2, 1'b1);
    wait_drain();
    tests_run++;
    if (last_data !== 16'h0001 || last_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL sat_clear: got %h ovf=%b required 0001/0", last_data, last_ovf);
    end
  endtask

  task automatic test_backpressure();
    int base = out_count;
    out_ready = 1'b0;
    send(8'h01, 2'b11, 2'd0, 1'b1);
    send(8'h02, 2'b11, 2'd0, 1'b0);
    drive(8'h04, 2'b11, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_in_ready: got %b required 0", in_ready); end
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 16'h0001) begin
        tests_failed++;
        $display("FAIL bp_hold: got v=%b data=%h required 1/0001", out_valid, out_data);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_accept();
    wait_drain();
    tests_run++;
    if (out_count - base != 3 || last_data !== 16'h0007) begin
      tests_failed++;
      $display("FAIL bp_drain: got %0d outputs last=%h required 3/0007", out_count - base, last_data);
    end
  endtask

  task automatic test_invalid_ch();
    int base = out_count;
    out_ready = 1'b1;
    send(8'h07, 2'b11, 2'd3, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    tests_run++;
    if (out_count != base || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL invalid_ch: got %0d outputs v=%b required 0/0", out_count - base, out_valid);
    end
    for (int c = 0; c < NCH; c++) send(8'h00, 2'b11, 2'(c), 1'b0);
    wait_drain();
    tests_run++;
    if (out_count - base != NCH) begin
      tests_failed++;
      $display("FAIL invalid_readback: got %0d outputs required %0d", out_count - base, NCH);
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    send(8'h05, 2'b11, 2'd1, 1'b1);
    send(8'h06, 2'b11, 2'd1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 16'h0000) begin
      tests_failed++;
      $display("FAIL midreset: got v=%b rdy=%b data=%h required 0/1/0000", out_valid, in_ready, out_data);
    end
    exp_q.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(8'h01, 2'b11, 2'd0, 1'b0);
    wait_drain();
    tests_run++;
    if (last_data !== 16'h0001 || last_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_add: got %h ovf=%b required 0001/0", last_data, last_ovf);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_saturation();
    test_backpressure();
    test_invalid_ch();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/opsel_accum.md
# opsel_accum

Parametrised, multi-channel successor to the team's single-channel operand-select/add datapath. Each input beat selects an operand derived from `in_data` by opcode, then adds it into one of `NCH` per-channel saturating accumulators. The result streams out through a two-stage valid/ready pipeline. It sits between a packet-field extractor (upstream) and the statistics register bank (downstream).

## Interface
- `WIDTH`, 8, input data width (≥2)
- `NCH`, 4, number of accumulator channels (≥1, need not be a power of two)
- `ACC_WIDTH`, 2*WIDTH, accumulator/output width (must be ≥ WIDTH+1)
- `CONST_VAL`, 5, constant operand for opcode 2'b10 (zero-extended to ACC_WIDTH)
- `CHW`, $clog2(NCH) (minimum 1), channel index width (derived)

Ports:
- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  reset: asynchronous, active-low; clock `clk`
- `in_valid`  in  1  input beat valid
- `in_ready`  out  1  block can accept a beat
- `in_data`  in  WIDTH  input data
- `in_op`  in  2  operand select
- `in_ch`  in  CHW  target channel
- `in_clr`  in  1  load the operand into the accumulator instead of adding it; also clears the overflow flag
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts the result
- `out_data`  out  ACC_WIDTH  accumulator value after the update
- `out_ch`  out  CHW  channel of the result
- `out_ovf`  out  1  sticky overflow flag of that channel, after the update

## Operation
- A beat is accepted when `in_valid && in_ready`.
- Operand selection is unsigned and zero-extended to ACC_WIDTH:
  - 2'b00: `in_data + 1`, computed in WIDTH+1 bits, so 8'hFF gives 9'h100.
  - 2'b01: `~in_data`, WIDTH bits.
  - 2'b10: `CONST_VAL`.
  - 2'b11: `in_data`.
- Stage 1 (S1) registers the operand, channel and clr flag, and sets `s1_valid`.
- Stage 2 (S2) reads `acc[ch]`, computes the update and writes `acc[ch]`. In the same edge it loads `out_data`, `out_ch` and `out_ovf` and sets `out_valid`.
- Accumulator update:
  - If clr: `acc = operand`, `ovf = 0`.
  - Otherwise: compute `sum = acc + operand` in ACC_WIDTH+1 bits. If the carry is set, `acc` becomes all-ones and `ovf[ch]` is set to 1. Otherwise `acc = sum`.
- `ovf[ch]` is sticky: it is cleared only by clr or by reset.
- Once `acc[ch]` is all-ones it stays there; a further add of 0 does not set `ovf`.
- Channel index ≥ NCH: the beat is accepted and consumed in S1. It makes no accumulator change and produces no output beat.
- Read-modify-write of `acc` happens entirely in S2, so back-to-back beats to the same channel need no forwarding logic and no stall.
- Output is held stable while `out_valid && !out_ready`.

## Timing
- `adv2 = s1_valid && (!out_valid || out_ready)`; S2 and the accumulators update only on `adv2`.
- `in_ready = !s1_valid || adv2` (combinational). There is no combinational path from `in_valid` to `in_ready`.
- Latency: a beat accepted at edge k presents `out_valid` after edge k+1 when there is no stall.
- Throughput: one beat per cycle with `out_ready` held high.
- Backpressure: with `out_ready` low, at most 2 beats are in flight (S1 plus output). `in_ready` drops after S1 fills.
- When `out_valid` is consumed and S1 is empty on the same edge, `out_valid` goes to 0.
- Reset is asynchronous and takes effect mid-operation. While `rst` = 0:
  - all `acc` = 0 and all `ovf` = 0
  - `s1_valid` = 0
  - `out_valid` = 0, `out_data` = 0, `out_ch` = 0, `out_ovf` = 0
  - `in_ready` = 1
- In-flight beats are discarded by reset.
- Release of `rst` is synchronised externally; the first beat can be accepted on the first edge after release.

## Test plan
- Single-beat latency (WIDTH=8, ACC_WIDTH=16, NCH=4, `out_ready`=1): beat op=00, data=8'hFF, ch=0, clr=1 accepted at edge 0 → after edge 1 `out_valid`=1, `out_data`=16'h0100, `out_ch`=0, `out_ovf`=0.
- Back-to-back accumulation: ch=1, clr=1 with op=11, data=3, then op=10, then op=01 with data=8'h0F, all on consecutive cycles → outputs 3, 8, 8+16'h00F0=16'h00F8 on consecutive cycles.
- Saturation: ch=2, clr=1 with op=11, data=8'hFF; then repeat op=01 with data=0 (adds 255 each beat) → the 257th add is the first whose carry is set. Required result: `out_data`=16'hFFFF with `out_ovf`=1. A following op=11, data=0 keeps 16'hFFFF with `out_ovf`=1. A clr beat with data=1 gives 1 with `out_ovf`=0.
- Backpressure: hold `out_ready`=0 and offer 3 beats → `in_ready`=0 after 2 are accepted. `out_data` is stable with no accumulator change for the 3rd beat. Raising `out_ready` drains the results in order with no loss or duplication.
- Invalid channel (NCH=3, CHW=2): a beat with ch=3 → accepted, no output beat, `acc[0..2]` unchanged.
- Reset mid-stream: assert `rst`=0 with S1 and the output both full → `out_valid`=0 and `in_ready`=1 immediately. After release, an add of 1 to ch=0 without clr yields 1.
